// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the host-side byte source and uart_tx_ctrl.
// The master (host) drives data/valid; the slave (controller) drives ready.
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer. Accepts one byte over a valid/ready
// handshake and serialises start, data (LSB first), optional parity and stop
// bits, each held for BAUD_DIV clocks.
// Optional feature macro: UART_TX_PARITY_EN (inserts a parity bit after DATA;
// PARITY_ODD selects odd parity). Undefined by default.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | line high, ready for a byte
//   ST_START  | start bit (line low)
//   ST_DATA   | data bits, shift[0] on the line, LSB first
//   ST_PARITY | parity of the latched byte (UART_TX_PARITY_EN only)
//   ST_STOP   | stop bit (line high), done pulses on exit
module uart_tx_ctrl #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_tx_ctrl_if.slave  bus,
  output logic           o_tx,
  output logic           o_busy,
  output logic           o_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_baud, w_baud_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  assign w_bit_end    = (r_baud == BAUD_LAST);
  assign bus.tx_ready = r_ready;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  // State register and registered outputs; tx is flopped so the pin never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (r_state == ST_STOP) && w_bit_end;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity comes from the byte as accepted, not from the shifting copy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par <= 1'b0;
    end else if (r_state == ST_IDLE && bus.tx_valid) begin
      r_par <= (^bus.tx_data) ^ (PARITY_ODD != 0);
    end
  end
`endif

  // Next-state, shift, bit and baud counter logic, plus the next line level.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;

    if (r_state != ST_IDLE) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud + CNT_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          w_state_nxt = ST_START;
          w_shift_nxt = bus.tx_data;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = r_par;
`endif
      default:   w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: cycle-accurate line checks per frame plus an
// independent line decoder fed by an expected-byte scoreboard.
module tb_uart_tx_ctrl;
  localparam int BAUD  = 4;
  localparam int DBITS = 8;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int FRAME = (1 + DBITS + NPAR + 1) * BAUD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy, done;

  uart_tx_ctrl_if #(.DATA_BITS(DBITS)) bus ();

  uart_tx_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(DBITS), .PARITY_ODD(PODD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  // seq: line order of the data bits, first bit transmitted in seq[7].
  // par: even parity of data.
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] seq, input logic par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DBITS) return seq[DBITS-idx];
    if (NPAR == 1 && idx == DBITS + 1) return par ^ PODD[0];
    return 1'b1;
  endfunction

  task automatic wait_ready();
    int i;
    for (i = 0; i < 100; i++) begin
      if (bus.tx_ready === 1'b1) break;
      @(negedge clk);
    end
    check("wait_ready", 32'(bus.tx_ready), 32'd1);
  endtask

  // mode 0: drop valid; 1: keep valid, present next_data; 2: disturb valid/data during DATA
  task automatic check_frame(input logic [7:0] seq, input logic par, input int mode,
                             input logic [7:0] next_data);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (mode == 1) begin
        if (c == 0) bus.tx_data = next_data;
      end else if (mode == 2 && c >= BAUD && c < (1 + DBITS) * BAUD) begin
        bus.tx_data  = 8'($urandom);
        bus.tx_valid = c[1];
      end else begin
        bus.tx_valid = 1'b0;
      end
      check("frame_tx", 32'(tx), 32'(exp_bit(seq, par, c / BAUD)));
      check("frame_ready", 32'(bus.tx_ready), 32'd0);
      check("frame_busy", 32'(busy), 32'd1);
      check("frame_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("end_done", 32'(done), 32'd1);
    check("end_ready", 32'(bus.tx_ready), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_tx", 32'(tx), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] seq, input logic par,
                      input int mode, input logic [7:0] next_data);
    wait_ready();
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{d: d, p: par});
    check_frame(seq, par, mode, next_data);
  endtask

  task automatic mwait(input int n, output logic hit);
    hit = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!rst_n) hit = 1'b1;
    end
  endtask

  // Line decoder: samples each bit mid-way and checks it against the scoreboard.
  initial begin
    logic [7:0] d;
    logic       p, s, ab, hit;
    exp_t       e;
    forever begin
      @(negedge clk);
      while (tx !== 1'b1) @(negedge clk);
      while (tx !== 1'b0) @(negedge clk);
      ab = !rst_n;
      p  = 1'b0;
      mwait(5, hit); ab |= hit;
      d[0] = tx;
      for (int i = 1; i < DBITS; i++) begin
        mwait(BAUD, hit); ab |= hit;
        d[i] = tx;
      end
      if (NPAR == 1) begin
        mwait(BAUD, hit); ab |= hit;
        p = tx;
      end
      mwait(BAUD, hit); ab |= hit;
      s = tx;
      if (!ab) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'(d), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(d), 32'(e.d));
          if (NPAR == 1) check("rx_parity", 32'(p), 32'(e.p ^ PODD[0]));
          check("rx_stop", 32'(s), 32'd1);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{data: 8'hA5, seq: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h00, seq: 8'h00, par: 1'b0};
    vecs[2] = '{data: 8'hFF, seq: 8'hFF, par: 1'b0};
    vecs[3] = '{data: 8'h01, seq: 8'h80, par: 1'b1};
    vecs[4] = '{data: 8'h12, seq: 8'h48, par: 1'b0};
    vecs[5] = '{data: 8'h07, seq: 8'hE0, par: 1'b1};
    vecs[6] = '{data: 8'h03, seq: 8'hC0, par: 1'b0};
    vecs[7] = '{data: 8'hFE, seq: 8'h7F, par: 1'b1};

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_ready", 32'(bus.tx_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    foreach (vecs[i]) send(vecs[i].data, vecs[i].seq, vecs[i].par, 0, 8'h00);

    // Back-to-back with tx_valid held: second start bit 41 cycles after the first handshake.
    send(8'h3C, 8'h3C, 1'b0, 1, 8'hC3);
    @(posedge clk);
    sb.push_back('{d: 8'hC3, p: 1'b0});
    check_frame(8'hC3, 1'b0, 0, 8'h00);

    // Mid-frame valid/data activity must be ignored.
    send(8'h0F, 8'hF0, 1'b0, 2, 8'h00);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_extra_tx", 32'(tx), 32'd1);
      check("no_extra_busy", 32'(busy), 32'd0);
    end

    // Reset during data bit 3 of 0xFF.
    wait_ready();
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    check("pre_abort_tx", 32'(tx), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(bus.tx_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_reset_tx", 32'(tx), 32'd1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("post_abort_tx", 32'(tx), 32'd1);
      check("post_abort_busy", 32'(busy), 32'd0);
    end
    send(8'h81, 8'h81, 1'b0, 0, 8'h00);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
